// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, 5-cycle multiply, 10-cycle divide.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) with MDU_MADD_EN.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        legal;
    logic        accept;
    logic        op_signed;
    logic [63:0] ax, bx;
    logic [63:0] prod;
    logic [63:0] mul_res;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] dvs;
    logic signed [31:0] sa, sd;
    logic [31:0] quo, rem;

    // Decode which operation codes this build recognises.
    always_comb begin
        legal = 1'b0;
        unique case (md_op)
            OP_MULT, OP_MULTU, OP_DIV,
            OP_DIVU, OP_MTHI, OP_MTLO: legal = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU:        legal = 1'b1;
`endif
            default:                  legal = 1'b0;
        endcase
    end

    assign accept = start & ~flush & ~busy_q & legal;

    // Arithmetic on the latched operands; consumed on the completion edge.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        op_signed = op_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        ax   = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        bx   = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod = ax * bx;
`ifdef MDU_MADD_EN
        unique case (op_q)
            OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
            default:           mul_res = prod;
        endcase
`else
        mul_res = prod;
`endif
        // Most-negative / -1 divides by 1 instead: quotient = dividend, rem 0.
        div_zero = (b_q == 32'd0);
        div_ovf  = op_signed && (a_q == 32'h8000_0000) &&
                   (b_q == 32'hFFFF_FFFF);
        dvs = (div_zero || div_ovf) ? 32'd1 : b_q;
        sa  = a_q;
        sd  = dvs;
        if (op_signed) begin
            quo = sa / sd;
            rem = sa % sd;
        end else begin
            quo = a_q / dvs;
            rem = a_q % dvs;
        end
    end

    // Next-state: accept requests when idle, count down, commit on expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (md_op == OP_MTHI) begin
                        hi_d = A;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = A;
                    end else begin
                        a_d    = A;
                        b_d    = B;
                        op_d   = md_op;
                        busy_d = 1'b1;
                        if (md_op == OP_DIV || md_op == OP_DIVU) begin
                            state_d = S_DIV;
                            cnt_d   = 4'd10;
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = 4'd5;
                        end
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    {hi_d, lo_d} = mul_res;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops vs. a
// plain-arithmetic model of HI/LO and busy duration.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_s, b_s;
    logic [3:0]  op_s;
    logic        start_s, flush_s;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu dut (
        .clk   (clk),
        .reset (rst),
        .A     (a_s),
        .B     (b_s),
        .md_op (op_s),
        .start (start_s),
        .flush (flush_s),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: updates m_hi/m_lo as the op would, returns busy cycles.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl,
                         output int cyc);
        longint      sp, sq, sr;
        logic [63:0] up, acc;
        bit          legal;
        legal = (op >= 4'd1 && op <= 4'd6);
`ifdef MDU_MADD_EN
        legal = legal || (op >= 4'd7 && op <= 4'd10);
`endif
        cyc = 0;
        if (!legal || fl) return;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        case (op)
            4'd1: begin {m_hi, m_lo} = sp; cyc = 5; end
            4'd2: begin {m_hi, m_lo} = up; cyc = 5; end
            4'd3: begin
                cyc = 10;
                if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
            end
            4'd4: begin
                cyc = 10;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            4'd7: begin {m_hi, m_lo} = acc + sp; cyc = 5; end
            4'd8: begin {m_hi, m_lo} = acc + up; cyc = 5; end
            4'd9: begin {m_hi, m_lo} = acc - sp; cyc = 5; end
            4'd10: begin {m_hi, m_lo} = acc - up; cyc = 5; end
            default: cyc = 0;
        endcase
    endtask

    // Issue one request from idle, optionally injecting a second request
    // during busy cycle inj, then check busy length and HI/LO.
    task automatic run(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input int inj = 0,
                       input logic [3:0] iop = 4'd0,
                       input logic [31:0] ia = 32'd0,
                       input logic ifl = 1'b0);
        int n;
        int exp_cyc;
        @(negedge clk);
        a_s = a; b_s = b; op_s = op; start_s = 1'b1; flush_s = fl;
        model(op, a, b, fl, exp_cyc);
        @(posedge clk);
        #1;
        start_s = 1'b0; flush_s = 1'b0; op_s = 4'd0;
        n = 0;
        while (n <= 40) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == inj) begin
                start_s = 1'b1; op_s = iop; a_s = ia; flush_s = ifl;
            end else begin
                start_s = 1'b0; flush_s = 1'b0;
            end
        end
        start_s = 1'b0; flush_s = 1'b0; op_s = 4'd0;
        check({tag, " busy_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, " HI"}, hi, m_hi);
        check({tag, " LO"}, lo, m_lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rfl;
        rst = 1'b1;
        a_s = '0; b_s = '0; op_s = '0; start_s = 1'b0; flush_s = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset HI", hi, 32'd0);
        check("reset LO", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult HI const", hi, 32'hFFFF_FFFF);
        check("mult LO const", lo, 32'hFFFF_FFFE);
        run("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu HI const", hi, 32'h0000_0001);
        check("multu LO const", lo, 32'hFFFF_FFFE);

        run("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div LO const", lo, 32'hFFFF_FFFD);
        check("div HI const", hi, 32'hFFFF_FFFF);
        run("divu_by0", 4'd4, 32'd7, 32'd0, 1'b0);
        run("div_by0", 4'd3, 32'h8000_0000, 32'd0, 1'b0);
        run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf LO const", lo, 32'h8000_0000);
        check("div_ovf HI const", hi, 32'h0000_0000);
        run("div_neg_div", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);

        run("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi HI const", hi, 32'h1234_5678);
        run("div_mtlo", 4'd3, 32'd100, 32'd7, 1'b0, 3, 4'd6, 32'hDEAD_BEEF);
        run("div_mthi", 4'd4, 32'd55, 32'd10, 1'b0, 10, 4'd5, 32'hCAFE_F00D);

        run("mult_flush", 4'd1, 32'd9, 32'd9, 1'b1);
        run("div_flush2", 4'd3, 32'd1000, 32'd3, 1'b0, 2, 4'd3, 32'd5, 1'b1);
        run("none", 4'd0, 32'd1, 32'd1, 1'b0);
        run("illegal_f", 4'd15, 32'd1, 32'd1, 1'b0);

        run("mthi0", 4'd5, 32'd0, 32'd0, 1'b0);
        run("mtlo_ones", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("maddu HI const", hi, 32'd1);
        check("maddu LO const", lo, 32'd0);
        run("msub", 4'd9, 32'd3, 32'hFFFF_FFFF, 1'b0);
`else
        check("maddu HI const", hi, 32'd0);
        check("maddu LO const", lo, 32'hFFFF_FFFF);
`endif

        // Reset during the 3rd busy cycle of a mult.
        run("pre_rst", 4'd2, 32'd12345, 32'd678, 1'b0);
        @(negedge clk);
        a_s = 32'd77; b_s = 32'd99; op_s = 4'd1; start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0; op_s = 4'd0;
        repeat (3) @(negedge clk);
        check("rst3 busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check("rst3 busy", 32'(busy), 32'd0);
        check("rst3 HI", hi, 32'd0);
        check("rst3 LO", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst3 busy_later", 32'(busy), 32'd0);
        check("rst3 HI_later", hi, 32'd0);
        check("rst3 LO_later", lo, 32'd0);

        // Reset coincident with the completion edge.
        @(negedge clk);
        a_s = 32'd77; b_s = 32'd99; op_s = 4'd2; start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0; op_s = 4'd0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("rst_end busy", 32'(busy), 32'd0);
        check("rst_end LO", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_end LO_later", lo, 32'd0);

        // Random ops.
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 7));
                1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            rfl = ($urandom_range(0, 7) == 0);
            run("rand", rop, ra, rb, rfl);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
